// File: rtl/event_debouncer.sv
// Debounces a raw, asynchronous event line into a clean level plus a one-cycle
// press strobe. A two-flop synchronizer feeds a four-state qualification FSM.
module event_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        raw_in,
  output logic        pulse,
  output logic        level,
  output logic        busy,
  output logic [1:0]  o_dbg_state,
  output logic [15:0] o_dbg_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [15:0] LP_LAST = DEBOUNCE_CYCLES - 16'd1;

  logic   r_q1;
  logic   r_q2;
  logic   w_sync;
  state_t r_state;
  logic [15:0] r_cnt;
  logic   r_pulse;
  logic   r_level;
  logic   r_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q1 <= 1'b0;
      r_q2 <= 1'b0;
    end else begin
      r_q1 <= raw_in;
      r_q2 <= r_q1;
    end
  end

  assign w_sync = r_q2;

  // Outputs are updated together with the state so they always describe the
  // state being entered; pulse defaults low so it can only last one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_sync) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= 16'd1;
            r_busy  <= 1'b1;
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_sync) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= ST_PRESSED;
            r_cnt   <= 16'd0;
            r_pulse <= 1'b1;
            r_level <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_PRESSED: begin
          if (!w_sync) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= 16'd1;
            r_busy  <= 1'b1;
          end
        end
        ST_RELEASE_WAIT: begin
          // A return to high here is a release glitch: back to PRESSED, no pulse.
          if (w_sync) begin
            r_state <= ST_PRESSED;
            r_cnt   <= 16'd0;
            r_busy  <= 1'b0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
            r_level <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 16'd0;
          r_level <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign pulse       = r_pulse;
  assign level       = r_level;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;
  assign o_dbg_cnt   = r_cnt;

endmodule
